// File: rtl/tqv_spi_bridge.sv
// SPI-slave (mode 0) to TinyQV peripheral register bus bridge.
// Optional read-wait timeout enabled by defining TQV_SPI_BRIDGE_TIMEOUT_EN.
module tqv_spi_bridge #(
   parameter int unsigned ADDR_W      = 6,
   parameter int unsigned REG_W       = 32,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              spi_cs_n,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] reg_addr,
   output logic              reg_rw,
   output logic [1:0]        txn_width,
   output logic [REG_W-1:0]  reg_data_o,
   output logic              reg_data_o_dv,
   output logic              reg_addr_v,
   input  logic [REG_W-1:0]  reg_data_i,
   input  logic              reg_data_i_dv
);
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned TURN_W = 4;

   typedef enum logic [2:0] {IDLE, HDR, WDATA, RWAIT, RTURN, RDATA, DONE} state_t;

   state_t              state_q, state_d;
   logic                sclk_q;
   logic                armed_q, armed_d;
   logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;
   logic [REG_W-1:0]    shift_q, shift_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                rw_q, rw_d;
   logic [1:0]          width_q, width_d;
   logic [REG_W-1:0]    wdata_q, wdata_d;
   logic                wdv_q, wdv_d;
   logic                addr_v_q, addr_v_d;
   logic                miso_q, miso_d;

   logic                rise, fall, cs_act, tmo_hit;
   logic [CNT_W-1:0]    nbits;
   logic [REG_W-1:0]    shift_in, rd_fill;

   assign rise     = spi_clk & ~sclk_q;
   assign fall     = ~spi_clk & sclk_q;
   assign cs_act   = ena & ~spi_cs_n;
   assign nbits    = CNT_W'(8) << width_q;
   assign shift_in = {shift_q[REG_W-2:0], spi_mosi};
   // Read data is left-aligned so MISO always shifts out of the MSB.
   assign rd_fill  = (reg_data_i_dv ? reg_data_i : {REG_W{1'b1}}) << (CNT_W'(REG_W) - nbits);

`ifdef TQV_SPI_BRIDGE_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;

   always_comb begin
      tmo_d = '0;
      if (addr_v_q) tmo_d = tmo_q + TMO_W'(1);
   end

   assign tmo_hit = addr_v_q && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tmo_q <= '0;
      else        tmo_q <= tmo_d;
   end
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYC;
   assign tmo_hit    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      armed_d    = armed_q;
      bit_cnt_d  = bit_cnt_q;
      turn_cnt_d = turn_cnt_q;
      shift_d    = shift_q;
      addr_d     = addr_q;
      rw_d       = rw_q;
      width_d    = width_q;
      wdata_d    = wdata_q;
      wdv_d      = 1'b0;
      addr_v_d   = addr_v_q;
      miso_d     = 1'b0;

      // A pending request ends on data or timeout, whatever state we are in.
      if (addr_v_q && (reg_data_i_dv || tmo_hit)) addr_v_d = 1'b0;

      if (!cs_act) begin
         state_d  = IDLE;
         armed_d  = 1'b1;
         addr_v_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: if (armed_q) begin
               state_d   = HDR;
               bit_cnt_d = '0;
               shift_d   = '0;
            end
            HDR: if (rise) begin
               shift_d   = shift_in;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_W'(15)) begin
                  rw_d       = shift_in[15];
                  width_d    = shift_in[9:8];
                  addr_d     = shift_in[ADDR_W-1:0];
                  bit_cnt_d  = '0;
                  turn_cnt_d = '0;
                  shift_d    = '0;
                  if (shift_in[9:8] == 2'b11) begin
                     state_d = DONE;
                  end else if (shift_in[15]) begin
                     state_d = WDATA;
                  end else begin
                     state_d  = RWAIT;
                     addr_v_d = 1'b1;
                  end
               end
            end
            WDATA: if (rise) begin
               shift_d   = shift_in;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == nbits - CNT_W'(1)) begin
                  wdata_d = shift_in;
                  wdv_d   = 1'b1;
                  state_d = DONE;
               end
            end
            RWAIT: begin
               if (rise) turn_cnt_d = turn_cnt_q + TURN_W'(1);
               if (reg_data_i_dv || tmo_hit) begin
                  shift_d = rd_fill;
                  state_d = RTURN;
               end
               // Turnaround over without data: stream zeros, keep waiting.
               if (rise && turn_cnt_q == TURN_W'(7)) begin
                  state_d   = RDATA;
                  bit_cnt_d = '0;
               end
            end
            RTURN: if (rise) begin
               turn_cnt_d = turn_cnt_q + TURN_W'(1);
               if (turn_cnt_q == TURN_W'(7)) begin
                  state_d   = RDATA;
                  bit_cnt_d = '0;
               end
            end
            RDATA: begin
               miso_d = miso_q;
               if (fall) begin
                  miso_d  = shift_q[REG_W-1];
                  shift_d = shift_q << 1;
               end
               if (rise) begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == nbits - CNT_W'(1)) begin
                     miso_d  = 1'b0;
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         sclk_q     <= 1'b0;
         armed_q    <= 1'b0;
         bit_cnt_q  <= '0;
         turn_cnt_q <= '0;
         shift_q    <= '0;
         addr_q     <= '0;
         rw_q       <= 1'b0;
         width_q    <= 2'b00;
         wdata_q    <= '0;
         wdv_q      <= 1'b0;
         addr_v_q   <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sclk_q     <= spi_clk;
         armed_q    <= armed_d;
         bit_cnt_q  <= bit_cnt_d;
         turn_cnt_q <= turn_cnt_d;
         shift_q    <= shift_d;
         addr_q     <= addr_d;
         rw_q       <= rw_d;
         width_q    <= width_d;
         wdata_q    <= wdata_d;
         wdv_q      <= wdv_d;
         addr_v_q   <= addr_v_d;
         miso_q     <= miso_d;
      end
   end

   assign spi_miso      = miso_q;
   assign reg_addr      = addr_q;
   assign reg_rw        = rw_q;
   assign txn_width     = width_q;
   assign reg_data_o    = wdata_q;
   assign reg_data_o_dv = wdv_q;
   assign reg_addr_v    = addr_v_q;
endmodule

// File: tb/tb_tqv_spi_bridge.sv
// Scoreboard bench for tqv_spi_bridge: host SPI driver, peripheral model, write/read monitors.
module tb_tqv_spi_bridge;
   localparam int HALF = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic        spi_cs_n = 1'b1;
   logic        spi_clk = 1'b0;
   logic        spi_mosi = 1'b0;
   logic        spi_miso;
   logic [5:0]  reg_addr;
   logic        reg_rw;
   logic [1:0]  txn_width;
   logic [31:0] reg_data_o;
   logic        reg_data_o_dv;
   logic        reg_addr_v;
   logic [31:0] reg_data_i = 32'h0;
   logic        reg_data_i_dv = 1'b0;

   always #5 clk = ~clk;

   tqv_spi_bridge dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .reg_addr(reg_addr), .reg_rw(reg_rw),
      .txn_width(txn_width), .reg_data_o(reg_data_o), .reg_data_o_dv(reg_data_o_dv),
      .reg_addr_v(reg_addr_v), .reg_data_i(reg_data_i), .reg_data_i_dv(reg_data_i_dv)
   );

   typedef struct packed {logic [5:0] addr; logic [1:0] w; logic [31:0] data;} wr_t;

   int          n_cmp = 0, n_bad = 0;
   wr_t         exp_wr[$];
   logic [31:0] exp_rd[$];
   logic [31:0] got_rd[$];
   int          per_lat = 0;
   logic [31:0] per_data = 32'h0;
   bit          quiet = 1'b0;
   int          quiet_viol = 0;
   int          hi_cnt = 0, last_hi = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
      end
   endtask

   function automatic logic [31:0] wmask(input logic [1:0] w);
      return (w == 2'd0) ? 32'h0000_00FF : (w == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input logic b, output logic m);
      spi_mosi = b;
      tick(HALF);
      m = spi_miso;
      spi_clk = 1'b1;
      tick(HALF);
      spi_clk = 1'b0;
   endtask

   task automatic spi_frame(input logic rw, input logic [1:0] w, input logic [5:0] a,
                            input logic [31:0] wd, input int ndata, input int nturn,
                            input bit hold_cs, output logic [31:0] rd);
      logic [15:0] hdr;
      logic        m;
      hdr = {rw, 5'b0, w, 2'b0, a};
      rd = 32'h0;
      spi_cs_n = 1'b0;
      tick(HALF);
      for (int i = 15; i >= 0; i--) spi_bit(hdr[i], m);
      for (int i = 0; i < nturn; i++) spi_bit(1'b0, m);
      for (int i = ndata - 1; i >= 0; i--) begin
         spi_bit(rw ? wd[i] : 1'($urandom), m);
         rd = {rd[30:0], m};
      end
      tick(HALF);
      if (!hold_cs) begin
         spi_cs_n = 1'b1;
         tick(2 * HALF);
      end
   endtask

   // Peripheral: answers per_lat cycles after seeing a request; stray strobes while idle.
   initial begin : periph
      int cnt;
      bit served;
      cnt = 0;
      served = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         reg_data_i_dv = 1'b0;
         reg_data_i = $urandom;
         if (!reg_addr_v) begin
            cnt = 0;
            served = 1'b0;
            if (rst_n && $urandom_range(0, 9) == 0) reg_data_i_dv = 1'b1;
         end else if (!served && per_lat != 0) begin
            cnt++;
            if (cnt == per_lat) begin
               reg_data_i = per_data;
               reg_data_i_dv = 1'b1;
               served = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin : wr_mon
      wr_t e;
      if (rst_n && reg_data_o_dv) begin
         if (exp_wr.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_strobe: got strobe data 0x%08h addr %0d, required no strobe",
                     reg_data_o, reg_addr);
         end else begin
            e = exp_wr.pop_front();
            check("wr_data", reg_data_o, e.data);
            check("wr_addr", 32'(reg_addr), 32'(e.addr));
            check("wr_width", 32'(txn_width), 32'(e.w));
            check("wr_rw", 32'(reg_rw), 32'd1);
         end
      end
   end

   always @(negedge clk) begin : rd_mon
      if (got_rd.size() > 0) begin
         if (exp_rd.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_read: got 0x%08h, required no read", got_rd.pop_front());
         end else begin
            check("rd_data", got_rd.pop_front(), exp_rd.pop_front());
         end
      end
   end

   always @(negedge clk) begin : side_mon
      if (quiet && (reg_addr_v || spi_miso)) quiet_viol++;
      if (reg_addr_v) hi_cnt++;
      else if (hi_cnt != 0) begin
         last_hi = hi_cnt;
         hi_cnt = 0;
      end
   end

   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: got no end of test, required finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] rd, d;
      logic [15:0] hdr;
      logic [1:0]  w;
      logic [5:0]  a;
      logic        m, rw;
      int          nb;

      ena = 1'b1;
      tick(3);
      check("rst_miso", 32'(spi_miso), 32'd0);
      check("rst_addr", 32'(reg_addr), 32'd0);
      check("rst_rw", 32'(reg_rw), 32'd0);
      check("rst_width", 32'(txn_width), 32'd0);
      check("rst_wdata", reg_data_o, 32'd0);
      check("rst_dv", 32'(reg_data_o_dv), 32'd0);
      check("rst_addr_v", 32'(reg_addr_v), 32'd0);
      rst_n = 1'b1;
      tick(4);

      exp_wr.push_back({6'd5, 2'd2, 32'hDEADBEEF});
      quiet = 1'b1;
      spi_frame(1'b1, 2'd2, 6'd5, 32'hDEADBEEF, 32, 0, 1'b0, rd);
      exp_wr.push_back({6'h3F, 2'd0, 32'h0000_00A5});
      spi_frame(1'b1, 2'd0, 6'h3F, 32'h0000_00A5, 8, 0, 1'b0, rd);
      quiet = 1'b0;

      per_lat = 4;
      per_data = 32'h1234_ABCD;
      exp_rd.push_back(32'h0000_ABCD);
      spi_frame(1'b0, 2'd1, 6'h0A, 32'h0, 16, 8, 1'b0, rd);
      got_rd.push_back(rd);
      check("rd16_addr_v_len", 32'(last_hi), 32'd4);
      check("rd16_addr", 32'(reg_addr), 32'h0A);
      check("rd16_rw", 32'(reg_rw), 32'd0);
      check("rd16_width", 32'(txn_width), 32'd1);

      quiet = 1'b1;
      spi_frame(1'b1, 2'd2, 6'd9, 32'hCAFEF00D, 10, 0, 1'b0, rd);
      check("abort_addr_hold", 32'(reg_addr), 32'd9);
      check("abort_wdata_hold", reg_data_o, 32'h0000_00A5);
      d = $urandom;
      exp_wr.push_back({6'd1, 2'd0, d & 32'hFF});
      spi_frame(1'b1, 2'd0, 6'd1, d, 8, 0, 1'b0, rd);

      spi_frame(1'b1, 2'd3, 6'd2, $urandom, 32, 0, 1'b0, rd);

      ena = 1'b0;
      spi_frame(1'b1, 2'd0, 6'd4, 32'h5A, 8, 0, 1'b0, rd);
      ena = 1'b1;
      tick(2);
      quiet = 1'b0;

      for (int k = 0; k < 24; k++) begin
         rw = 1'($urandom);
         w  = 2'($urandom_range(0, 2));
         a  = 6'($urandom);
         d  = $urandom;
         nb = 8 << w;
         if (rw) begin
            exp_wr.push_back({a, w, d & wmask(w)});
            quiet = 1'b1;
            spi_frame(1'b1, w, a, d, nb, 0, 1'b0, rd);
            quiet = 1'b0;
         end else begin
            per_lat = $urandom_range(1, 40);
            per_data = d;
            exp_rd.push_back(d & wmask(w));
            spi_frame(1'b0, w, a, 32'h0, nb, 8, 1'b0, rd);
            got_rd.push_back(rd);
            check("rnd_addr_v_len", 32'(last_hi), 32'(per_lat));
            check("rnd_rd_addr", 32'(reg_addr), 32'(a));
         end
      end

      per_lat = 0;
`ifdef TQV_SPI_BRIDGE_TIMEOUT_EN
      exp_rd.push_back(32'hFFFF_FFFF);
`else
      exp_rd.push_back(32'h0);
`endif
      spi_frame(1'b0, 2'd2, 6'd7, 32'h0, 32, 8, 1'b1, rd);
      got_rd.push_back(rd);
`ifdef TQV_SPI_BRIDGE_TIMEOUT_EN
      check("stall_addr_v_before_cs", 32'(reg_addr_v), 32'd0);
      check("tmo_addr_v_len", 32'(last_hi), 32'd64);
`else
      check("stall_addr_v_before_cs", 32'(reg_addr_v), 32'd1);
`endif
      spi_cs_n = 1'b1;
      tick(2);
      check("stall_addr_v_after_cs", 32'(reg_addr_v), 32'd0);
      tick(2 * HALF);

      hdr = 16'h0203;
      spi_cs_n = 1'b0;
      tick(HALF);
      for (int i = 15; i >= 0; i--) spi_bit(hdr[i], m);
      spi_bit(1'b0, m);
      spi_bit(1'b0, m);
      check("pre_reset_addr_v", 32'(reg_addr_v), 32'd1);
      check("pre_reset_addr", 32'(reg_addr), 32'd3);
      rst_n = 1'b0;
      #1;
      check("mid_reset_addr_v", 32'(reg_addr_v), 32'd0);
      check("mid_reset_addr", 32'(reg_addr), 32'd0);
      check("mid_reset_width", 32'(txn_width), 32'd0);
      check("mid_reset_wdata", reg_data_o, 32'd0);
      tick(2);
      rst_n = 1'b1;
      tick(2);
      quiet = 1'b1;
      hdr = 16'h8001;
      for (int i = 15; i >= 0; i--) spi_bit(hdr[i], m);
      for (int i = 0; i < 8; i++) spi_bit(1'($urandom), m);
      tick(HALF);
      spi_cs_n = 1'b1;
      tick(2 * HALF);
      d = $urandom;
      exp_wr.push_back({6'd12, 2'd1, d & 32'hFFFF});
      spi_frame(1'b1, 2'd1, 6'd12, d, 16, 0, 1'b0, rd);
      quiet = 1'b0;

      tick(20);
      check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
      check("quiet_violations", 32'(quiet_viol), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
